// File: rtl/alu_issue.sv
// Decode/issue front end for the registered ALU: accepts one RV32I OP/OP-IMM/LUI/AUIPC
// instruction, drives ALU operands, and writes the result back. Optional counters: ALU_ISSUE_PERF_EN.
//
// state    | meaning
// IDLE     | ready for an instruction; latch word and PC on handshake
// RFWAIT   | synchronous register-file read in progress (RF_READ_LAT=1 only)
// DECODE   | operands/func/control registered; illegal pulses here
// EXEC     | operands stable, ALU samples them at the closing edge
// WB       | ALU result written back to rd (suppressed for x0)
module alu_issue #(
  parameter int RF_READ_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] alu_in_A,
  output logic [31:0] alu_in_B,
  output logic [2:0]  alu_func,
  output logic        alu_control,
  input  logic [31:0] alu_out,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        illegal,
  output logic        busy
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0] retired_count,
  output logic [31:0] illegal_count
`endif
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RFWAIT,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t      state;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [2:0]  dec_func;
  logic        dec_ctrl;

  // Legality depends only on the instruction word, so it can be judged before operands arrive.
  function automatic logic is_legal(input logic [31:0] w);
    logic       f7_alt_ok;
    logic       f7_zero;
    f7_zero   = (w[31:25] == 7'b0000000);
    f7_alt_ok = f7_zero || (w[31:25] == 7'b0100000);
    case (w[6:0])
      OPC_OP:    is_legal = (w[14:12] == 3'b000 || w[14:12] == 3'b101) ? f7_alt_ok : f7_zero;
      OPC_IMM:   is_legal = (w[14:12] == 3'b001) ? f7_zero :
                            (w[14:12] == 3'b101) ? f7_alt_ok : 1'b1;
      OPC_LUI:   is_legal = 1'b1;
      OPC_AUIPC: is_legal = 1'b1;
      default:   is_legal = 1'b0;
    endcase
  endfunction

  assign op = instr_q[6:0];
  assign f3 = instr_q[14:12];
  assign f7 = instr_q[31:25];

  always_comb begin
    dec_a    = rs1_data;
    dec_b    = rs2_data;
    dec_func = f3;
    dec_ctrl = 1'b0;
    case (op)
      OPC_OP: begin
        if (f3 == 3'b000 && f7[5]) begin
          dec_b = 32'd0 - rs2_data;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
          dec_b    = {27'b0, rs2_data[4:0]};
          dec_ctrl = f7[5];
        end
      end
      OPC_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec_b    = {27'b0, instr_q[24:20]};
          dec_ctrl = f7[5];
        end else begin
          dec_b = {{20{instr_q[31]}}, instr_q[31:20]};
        end
      end
      OPC_LUI: begin
        dec_a    = {instr_q[31:12], 12'b0};
        dec_b    = 32'd0;
        dec_func = 3'b000;
        dec_ctrl = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a    = pc_q;
        dec_b    = {instr_q[31:12], 12'b0};
        dec_func = 3'b000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      pc_q        <= '0;
      alu_in_A    <= '0;
      alu_in_B    <= '0;
      alu_func    <= '0;
      alu_control <= 1'b0;
      rd_we       <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      rd_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            pc_q    <= instr_pc;
            if (RF_READ_LAT != 0) begin
              state <= S_RFWAIT;
            end else begin
              state   <= S_DECODE;
              illegal <= !is_legal(instr);
            end
          end
        end
        S_RFWAIT: begin
          state   <= S_DECODE;
          illegal <= !is_legal(instr_q);
        end
        S_DECODE: begin
          illegal <= 1'b0;
          if (illegal) begin
            state <= S_IDLE;
          end else begin
            alu_in_A    <= dec_a;
            alu_in_B    <= dec_b;
            alu_func    <= dec_func;
            alu_control <= dec_ctrl;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_WB;
          rd_we <= (instr_q[11:7] != 5'd0);
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign rs1_addr    = instr_q[19:15];
  assign rs2_addr    = instr_q[24:20];
  assign rd_addr     = instr_q[11:7];
  // The registered ALU result only appears during WB, so it is forwarded rather than re-registered.
  assign rd_data     = rd_we ? alu_out : 32'd0;

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
      illegal_count <= '0;
    end else begin
      if (state == S_WB) retired_count <= retired_count + 32'd1;
      if (state == S_DECODE && illegal) illegal_count <= illegal_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: one combinational-read instance and one synchronous-read
// instance, each with a registered ALU and register-file model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [31:0] instr = '0, instr_pc = '0;
  logic [31:0] rf [32];

  logic        rdy_0, rdy_1, we_0, we_1, ill_0, ill_1, busy_0, busy_1, ctl_0, ctl_1;
  logic [4:0]  ra1_0, ra2_0, ra1_1, ra2_1, wa_0, wa_1;
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1, a_0, b_0, a_1, b_1, ao_0, ao_1, wd_0, wd_1;
  logic [2:0]  fn_0, fn_1;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] rc_0, ic_0, rc_1, ic_1;
`endif

  int n_cmp = 0, n_mis = 0;
  int lat, n_we, n_ill;
  logic        rdy_c;
  logic [31:0] cap_a, cap_b, cap_data;
  logic [2:0]  cap_f;
  logic        cap_c;
  logic [4:0]  cap_addr;

  always #5 clk = ~clk;

  alu_issue #(.RF_READ_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v0), .instr_ready(rdy_0),
    .instr(instr), .instr_pc(instr_pc), .rs1_addr(ra1_0), .rs2_addr(ra2_0),
    .rs1_data(rd1_0), .rs2_data(rd2_0), .alu_in_A(a_0), .alu_in_B(b_0),
    .alu_func(fn_0), .alu_control(ctl_0), .alu_out(ao_0), .rd_we(we_0),
    .rd_addr(wa_0), .rd_data(wd_0), .illegal(ill_0), .busy(busy_0)
`ifdef ALU_ISSUE_PERF_EN
    , .retired_count(rc_0), .illegal_count(ic_0)
`endif
  );

  alu_issue #(.RF_READ_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v1), .instr_ready(rdy_1),
    .instr(instr), .instr_pc(instr_pc), .rs1_addr(ra1_1), .rs2_addr(ra2_1),
    .rs1_data(rd1_1), .rs2_data(rd2_1), .alu_in_A(a_1), .alu_in_B(b_1),
    .alu_func(fn_1), .alu_control(ctl_1), .alu_out(ao_1), .rd_we(we_1),
    .rd_addr(wa_1), .rd_data(wd_1), .illegal(ill_1), .busy(busy_1)
`ifdef ALU_ISSUE_PERF_EN
    , .retired_count(rc_1), .illegal_count(ic_1)
`endif
  );

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f, input logic c);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'b0, $signed(a) < $signed(b)};
      3'd3:    return {31'b0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return c ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign rd1_0 = rf[ra1_0];
  assign rd2_0 = rf[ra2_0];
  always_ff @(posedge clk) begin
    rd1_1 <= rf[ra1_1];
    rd2_1 <= rf[ra2_1];
    ao_0  <= alu_model(a_0, b_0, fn_0, ctl_0);
    ao_1  <= alu_model(a_1, b_1, fn_1, ctl_1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Offer one instruction, then watch cycles 1..7 after the acceptance edge.
  task automatic issue(input bit sel, input logic [31:0] w, input logic [31:0] pc);
    @(negedge clk);
    instr = w;
    instr_pc = pc;
    if (sel) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    v1 = 1'b0;
    rdy_c = sel ? rdy_1 : rdy_0;
    lat = 0; n_we = 0; n_ill = 0;
    for (int k = 1; k <= 7; k++) begin
      if (sel ? ill_1 : ill_0) n_ill++;
      if (sel ? we_1 : we_0) begin
        n_we++;
        lat = k;
        cap_addr = sel ? wa_1 : wa_0;
        cap_data = sel ? wd_1 : wd_0;
      end
      if (k == (sel ? 3 : 2)) begin
        cap_a = sel ? a_1 : a_0;
        cap_b = sel ? b_1 : b_0;
        cap_f = sel ? fn_1 : fn_0;
        cap_c = sel ? ctl_1 : ctl_0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", a_0, 0);
    check("rst_b", b_0, 0);
    check("rst_func_ctl", {fn_0, ctl_0}, 0);
    check("rst_we_ill", {we_0, ill_0}, 0);
    check("rst_rd", {wa_0, wd_0}, 0);
    check("rst_ready", rdy_0, 1);
    @(negedge clk) rst_n = 1'b1;

    issue(0, 32'hFFF00293, 32'h0);                // ADDI x5,x0,-1
    check("addi_ready_drop", rdy_c, 0);
    check("addi_lat", lat, 3);
    check("addi_nwe", n_we, 1);
    check("addi_addr", cap_addr, 5);
    check("addi_data", cap_data, 32'hFFFFFFFF);
    check("addi_idle", rdy_0, 1);

    rf[1] = 32'd5; rf[2] = 32'd7;
    issue(0, 32'h402081B3, 32'h4);                // SUB x3,x1,x2
    check("sub_b", cap_b, 32'hFFFFFFF9);
    check("sub_fc", {cap_f, cap_c}, 4'b0000);
    check("sub_data", cap_data, 32'hFFFFFFFE);
    check("sub_addr", cap_addr, 3);

    rf[1] = 32'h80000000; rf[2] = 32'h00000024;
    issue(0, 32'h4020D233, 32'h8);                // SRA x4,x1,x2
    check("sra_b", cap_b, 4);
    check("sra_fc", {cap_f, cap_c}, 4'b1011);
    check("sra_data", cap_data, 32'hF8000000);

    issue(0, 32'h00001317, 32'h100);              // AUIPC x6,0x1
    check("auipc_a", cap_a, 32'h100);
    check("auipc_b", cap_b, 32'h1000);
    check("auipc_data", cap_data, 32'h1100);

    issue(0, 32'h40209293, 32'h104);              // SLLI with funct7=0100000
    check("badslli_ill", n_ill, 1);
    check("badslli_nwe", n_we, 0);
    check("badslli_hold_b", cap_b, 32'h1000);
    check("badslli_idle", rdy_0, 1);

    issue(0, 32'h123450B7, 32'h108);              // LUI x1,0x12345
    check("lui_a", cap_a, 32'h12345000);
    check("lui_ctl", cap_c, 1);
    check("lui_data", cap_data, 32'h12345000);
    check("lui_lat", lat, 3);

    issue(1, 32'h123450B7, 32'h108);
    check("lui1_lat", lat, 4);
    check("lui1_data", cap_data, 32'h12345000);
    check("lui1_idle", rdy_1, 1);

    rf[1] = 32'd9; rf[2] = 32'd3;
    issue(1, 32'h402081B3, 32'h10C);              // SUB through the synchronous read path
    check("sub1_b", cap_b, 32'hFFFFFFFD);
    check("sub1_data", cap_data, 32'd6);

    pulse_reset();
    issue(0, 32'h00000073, 32'h200);              // ECALL
    check("ecall_ill", n_ill, 1);
    check("ecall_nwe", n_we, 0);
    check("ecall_idle", rdy_0, 1);
    issue(0, 32'h00100013, 32'h204);              // ADDI x0,x0,1
    check("x0_nwe", n_we, 0);
    check("x0_ill", n_ill, 0);
`ifdef ALU_ISSUE_PERF_EN
    check("perf_illegal", ic_0, 1);
    check("perf_retired", rc_0, 1);
`endif

    @(negedge clk);
    instr = 32'hFFF00293;
    v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(posedge clk); #1;
    check("exec_b", b_0, 32'hFFFFFFFF);
    rst_n = 1'b0;
    #1;
    check("rstx_b", b_0, 0);
    check("rstx_a_fc", {a_0, fn_0, ctl_0}, 0);
    check("rstx_rd", {we_0, wa_0, wd_0, ill_0}, 0);
    n_we = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (we_0) n_we++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (we_0) n_we++;
    end
    check("rstx_nwe", n_we, 0);
    check("rstx_ready", rdy_0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
